// File: rtl/soc_pkg.sv
// Shared definitions for the SoC memory-side blocks.
//   state_t      : responder FSM encoding (IDLE, DATA, RESP)
//   REGION_*     : cpu_addr[31:28] region nibbles
//   LANE_W       : width of a byte-lane select within a 32-bit word
//   lane_byte()  : extracts one byte lane from a 32-bit RAM word
package soc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] REGION_ROM    = 4'h0;
    localparam logic [3:0] REGION_RAM    = 4'h1;
    localparam logic [3:0] REGION_USBREG = 4'h2;

    localparam int LANE_W  = 2;
    localparam int LANES   = 4;

    function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                             input logic [LANE_W-1:0] lane);
        return word[8*lane +: 8];
    endfunction

endpackage

// File: rtl/usb_byte_port.sv
// USB byte-port adapter for the shared 32-bit RAM.
//   usb_wen/usb_ren/usb_lane/usb_wdata : USB byte access (lane = byte addr[1:0])
//   lane_wdata/lane_wstrb              : replicated write byte and one-hot strobe
//   ram_rdata                          : registered RAM read word
//   usb_rdata                          : read byte; live on the completion cycle,
//                                        otherwise the last completed read byte
module usb_byte_port
    import soc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              usb_wen,
    input  logic              usb_ren,
    input  logic [LANE_W-1:0] usb_lane,
    input  logic [7:0]        usb_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       lane_wdata,
    output logic [3:0]        lane_wstrb,
    output logic [7:0]        usb_rdata
);

    logic [LANE_W-1:0] rd_lane;
    logic              rd_pend;
    logic [7:0]        rd_hold;
    logic [7:0]        rd_byte;

    assign lane_wdata = {LANES{usb_wdata}};
    assign lane_wstrb = {3'b000, usb_wen} << usb_lane;

    assign rd_byte   = lane_byte(ram_rdata, rd_lane);
    assign usb_rdata = rd_pend ? rd_byte : rd_hold;

    // A simultaneous wen+ren is a write; no read completion is scheduled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_lane <= '0;
            rd_pend <= 1'b0;
            rd_hold <= '0;
        end else begin
            rd_pend <= usb_ren && !usb_wen;
            if (usb_ren && !usb_wen)
                rd_lane <= usb_lane;
            if (rd_pend)
                rd_hold <= rd_byte;
        end
    end

endmodule

// File: rtl/shared_ram_responder.sv
// Memory-side responder for the shared byte-lane RAM. Arbitrates between the
// picorv32 native bus and the USB byte port; USB always wins, the CPU retries.
//   cpu_*         : picorv32 native memory bus (cpu_ready is a registered pulse)
//   usb_*         : USB device byte port
//   ram_*         : four-lane spram control, ram_rdata valid the cycle after ram_ce
//   cpu_wait_cnt  : saturating count of cycles stolen from the pending CPU request
//   starved       : sticky, set once STARVE_LIMIT consecutive cycles are stolen
//
// state | meaning
// IDLE  | waiting for a selected CPU request; issues it when USB is quiet
// DATA  | CPU read word on ram_rdata, captured into cpu_rdata
// RESP  | cpu_ready high for this cycle; wait count cleared on exit
module shared_ram_responder
    import soc_pkg::*;
#(
    parameter int         AW           = 10,
    parameter logic [3:0] BASE         = REGION_RAM,
    parameter int         STARVE_LIMIT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_valid,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [3:0]    cpu_wstrb,
    output logic          cpu_ready,
    output logic [31:0]   cpu_rdata,
    input  logic          usb_wen,
    input  logic          usb_ren,
    input  logic [AW-1:0] usb_addr,
    input  logic [7:0]    usb_wdata,
    output logic [7:0]    usb_rdata,
    output logic          ram_ce,
    output logic [AW-3:0] ram_addr,
    output logic [31:0]   ram_wdata,
    output logic [3:0]    ram_wstrb,
    input  logic [31:0]   ram_rdata,
    output logic [7:0]    cpu_wait_cnt,
    output logic          starved
);

    localparam logic [7:0] STARVE_M1 = 8'(STARVE_LIMIT - 1);

    state_t      state;
    logic        sel;
    logic        usb_acc;
    logic        issue;
    logic [31:0] usb_lane_wdata;
    logic [3:0]  usb_lane_wstrb;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{cpu_addr[27:AW], cpu_addr[1:0]};

    assign sel     = cpu_valid && (cpu_addr[31:28] == BASE);
    assign usb_acc = usb_wen | usb_ren;
    assign issue   = (state == ST_IDLE) && sel && !usb_acc;

    usb_byte_port u_usb_port (
        .clk        (clk),
        .rst        (rst),
        .usb_wen    (usb_wen),
        .usb_ren    (usb_ren),
        .usb_lane   (usb_addr[LANE_W-1:0]),
        .usb_wdata  (usb_wdata),
        .ram_rdata  (ram_rdata),
        .lane_wdata (usb_lane_wdata),
        .lane_wstrb (usb_lane_wstrb),
        .usb_rdata  (usb_rdata)
    );

    always_comb begin
        ram_ce    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wstrb = '0;
        if (usb_acc) begin
            ram_ce    = 1'b1;
            ram_addr  = usb_addr[AW-1:2];
            ram_wdata = usb_lane_wdata;
            ram_wstrb = usb_lane_wstrb;
        end else if (issue) begin
            ram_ce    = 1'b1;
            ram_addr  = cpu_addr[AW-1:2];
            ram_wdata = cpu_wdata;
            ram_wstrb = cpu_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cpu_ready    <= 1'b0;
            cpu_rdata    <= '0;
            cpu_wait_cnt <= '0;
            starved      <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel) begin
                        if (usb_acc) begin
                            if (cpu_wait_cnt != 8'hFF)
                                cpu_wait_cnt <= cpu_wait_cnt + 8'd1;
                            if (cpu_wait_cnt == STARVE_M1)
                                starved <= 1'b1;
                        end else if (cpu_wstrb != 4'b0000) begin
                            state     <= ST_RESP;
                            cpu_ready <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // ram_rdata holds the CPU word even if USB uses the RAM now.
                    cpu_rdata <= ram_rdata;
                    cpu_ready <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    // cpu_valid seen here belongs to the request just completed.
                    cpu_wait_cnt <= '0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/shared_ram_responder.md
Name: shared_ram_responder

Overview:
- Memory-side responder for the SoC's shared byte-lane RAM. Serves two initiators: the picorv32 native bus (CPU) and the USB device's byte port.
- Owns the RAM control signals and the USB byte-lane steering. Generates a registered `cpu_ready` and holds read data stable for both initiators.
- USB has absolute priority. The CPU is retried whenever USB takes the RAM cycle, and starvation is reported through a wait counter and a sticky flag.
- Sits between `u_cpu`, `u_usb_dev` and the four 8-bit spram lanes in `soc_top`. It replaces the inline arbitration logic there.

Parameters:
- AW, 10, byte-address width of the shared RAM. The RAM word address is AW-2 bits.
- BASE, 4'h1, value of `cpu_addr[31:28]` that selects this RAM.
- STARVE_LIMIT, 64, count of consecutive lost CPU cycles that sets the `starved` flag (range 1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- cpu_valid  in  1  picorv32 mem_valid
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_wstrb  in  4  byte strobes; 0 means read
- cpu_ready  out  1  registered, one-cycle completion pulse
- cpu_rdata  out  32  read data, valid while `cpu_ready` is high
- usb_wen  in  1  USB byte write
- usb_ren  in  1  USB byte read
- usb_addr  in  AW  USB byte address
- usb_wdata  in  8  USB write byte
- usb_rdata  out  8  USB read byte
- ram_ce  out  1  RAM enable
- ram_addr  out  AW-2  RAM word address
- ram_wdata  out  32  RAM write data
- ram_wstrb  out  4  per-lane write enable
- ram_rdata  in  32  RAM read data, registered, valid the cycle after `ram_ce`
- cpu_wait_cnt  out  8  saturating count of USB-stolen cycles for the current CPU request
- starved  out  1  sticky; set when `cpu_wait_cnt` reaches STARVE_LIMIT

Behaviour:
- Reset state: IDLE. `cpu_ready`=0, `cpu_rdata`=0, `usb_rdata`=0, `cpu_wait_cnt`=0, `starved`=0. Capture and hold registers are cleared.
- Reset asserted mid-transaction aborts the transaction; no `cpu_ready` is issued.
- `sel` = `cpu_valid` && `cpu_addr[31:28]`==BASE.
- Unselected CPU requests are ignored; `cpu_ready` stays 0.
- `usb_acc` = `usb_wen` | `usb_ren`. If both are high, the access is a write, and no read capture is scheduled.
- RAM mux, combinational:
  - If `usb_acc`: `ram_addr`=`usb_addr[AW-1:2]`, `ram_wdata`={4{`usb_wdata`}}, `ram_wstrb`=`usb_wen` << `usb_addr[1:0]`, `ram_ce`=1.
  - Else, when the FSM issues: `ram_addr`=`cpu_addr[AW-1:2]`, `ram_wdata`=`cpu_wdata`, `ram_wstrb`=`cpu_wstrb`, `ram_ce`=1.
  - Otherwise `ram_ce`=0 and `ram_wstrb`=0.
- FSM states:
  - IDLE:
    - `sel` && `usb_acc`: stay in IDLE, do not issue; `cpu_wait_cnt`++ (saturating at 255).
    - `sel` && !`usb_acc`: issue the CPU access. A write (`cpu_wstrb`!=0) goes to RESP. A read goes to DATA.
  - DATA: capture `ram_rdata` into `cpu_rdata`; go to RESP. A USB access in this cycle is allowed; the CPU data is already on `ram_rdata`.
  - RESP: `cpu_ready`=1 for exactly this cycle; `cpu_wait_cnt` clears to 0; go to IDLE.
- CPU latency, uncontended: write `cpu_ready` at t+1; read `cpu_ready` at t+2. Each contended IDLE cycle adds 1.
- Back-to-back requests: a new `sel` in the cycle after RESP is served normally. `cpu_valid` seen during RESP is not re-issued.
- `starved` is set when `cpu_wait_cnt`==STARVE_LIMIT-1 and another cycle is lost. It clears only on `rst`.
- USB read path:
  - On `usb_ren` at t, register lane = `usb_addr[1:0]` and a pending bit.
  - At t+1, `usb_rdata` = selected byte of `ram_rdata` (combinational), and the same byte is loaded into the hold register.
  - Otherwise `usb_rdata` = hold register, stable until the next USB read completes.
  - Back-to-back `usb_ren` is supported every cycle.
- CPU `cpu_rdata` holds its captured value until the next CPU read capture.

Decomposition:
- Shared package (`soc_pkg`): FSM state encoding (IDLE, DATA, RESP), region nibble constants (ROM=0, RAM=1, USBREG=2), lane-select helper constant widths.
- One natural sub-module, `usb_byte_port`: USB strobe/wdata replication, lane register, pending bit, and the `usb_rdata` hold mux.
- Everything else stays in the top.

Test Plan:
- CPU write `cpu_addr`=0x1000_0008, wdata=0xA5A5_1234, wstrb=0xF, no USB → `ram_wstrb`=0xF and `ram_addr`=2 at t; `cpu_ready`=1 at t+1 only.
- CPU read of 0x1000_0008 with `ram_rdata`=0xDEAD_BEEF at t+1 → `cpu_ready` at t+2 with `cpu_rdata`=0xDEAD_BEEF. Then change `ram_rdata`; `cpu_rdata` is unchanged.
- USB write `usb_addr`=0x00B, wdata=0x5C, concurrent with a CPU read → `ram_wstrb`=4'b1000, `ram_wdata`=0x5C5C5C5C. The CPU issue is deferred 1 cycle; `cpu_ready` at t+3; `cpu_wait_cnt`=1 before ready, 0 after.
- USB read `usb_addr`=0x006 with `ram_rdata`=0x11223344 at t+1 → `usb_rdata`=0x22 at t+1. Then a CPU read changes `ram_rdata`; `usb_rdata` stays 0x22.
- STARVE_LIMIT=4, USB access every cycle for 6 cycles while the CPU is pending → `cpu_wait_cnt` reaches 6 and `starved`=1 from the 4th lost cycle. The CPU completes after USB releases; `starved` remains 1 until `rst`.
- Assert `rst` in DATA of a CPU read → no `cpu_ready`, FSM in IDLE, all outputs 0. A CPU request with `cpu_addr`=0x2000_0000 → never ready, `ram_ce`=0.
